// File: rtl/or1k_store_buffer_pkg.sv
// Shared types for the OR1K posted-write store buffer: FSM state encoding and
// the buffered store entry layout.
package or1k_sb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } sb_state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  bsel;
    } sb_entry_t;

endpackage

// File: rtl/or1k_store_buffer_if.sv
// Request-side bus bundle between the store buffer and the Wishbone bus
// interface; signal names follow the store buffer's point of view.
interface or1k_store_buffer_if;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_adr_o;
    logic [31:0] bus_dat_o;
    logic [3:0]  bus_bsel_o;
    logic        bus_burst_o;
    logic        bus_ack_i;
    logic        bus_err_i;
    logic [31:0] bus_dat_i;

    modport master (
        output bus_req_o,
        output bus_we_o,
        output bus_adr_o,
        output bus_dat_o,
        output bus_bsel_o,
        output bus_burst_o,
        input  bus_ack_i,
        input  bus_err_i,
        input  bus_dat_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_we_o,
        input  bus_adr_o,
        input  bus_dat_o,
        input  bus_bsel_o,
        input  bus_burst_o,
        output bus_ack_i,
        output bus_err_i,
        output bus_dat_i
    );

endinterface

// File: rtl/or1k_store_buffer_fifo.sv
// DEPTH-entry FIFO of buffered stores with a combinational head; only the
// pointers and occupancy count are reset, the entry storage is not.
module or1k_sb_fifo
    import or1k_sb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  sb_entry_t                  wr_entry,
    output sb_entry_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t        mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == '0);
    assign count  = count_r;
    assign head   = mem_r[rd_ptr_r];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, written at the tail
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_entry;
        end
    end

endmodule

// File: rtl/or1k_store_buffer.sv
// Posted-write store buffer: stores are acknowledged on FIFO entry and drained
// one bus transaction at a time; loads issue only once the buffer has emptied.
module or1k_store_buffer
    import or1k_sb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [31:0]         lsu_adr_i,
    input  logic [31:0]         lsu_dat_i,
    input  logic [3:0]          lsu_bsel_i,
    output logic                lsu_ack_o,
    output logic                lsu_err_o,
    output logic [31:0]         lsu_dat_o,
    output logic                sb_empty_o,
    output logic                sb_full_o,
    output logic                store_err_o,
    input  logic                store_err_clr_i,
    or1k_store_buffer_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    sb_state_t     state_r;
    logic [31:0]   bus_adr_r;
    logic [31:0]   bus_dat_r;
    logic [3:0]    bus_bsel_r;
    logic          store_err_r;
    logic          push_s;
    logic          pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    sb_entry_t     wr_entry_s;
    sb_entry_t     head_s;

    assign wr_entry_s = '{adr: lsu_adr_i, dat: lsu_dat_i, bsel: lsu_bsel_i};

    or1k_sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .pop      (pop_s),
        .wr_entry (wr_entry_s),
        .head     (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s)
    );

    // LSU handshake: store accept, drain pop, and pass-through load response
    always_comb begin
        push_s    = lsu_req_i & lsu_we_i & ~fifo_full_s;
        pop_s     = 1'b0;
        lsu_ack_o = push_s;
        lsu_err_o = 1'b0;
        lsu_dat_o = 32'h0000_0000;
        case (state_r)
            DRAIN: begin
                pop_s = bus.bus_ack_i | bus.bus_err_i;
            end
            LOAD: begin
                lsu_ack_o = push_s | bus.bus_ack_i;
                lsu_err_o = bus.bus_err_i;
                lsu_dat_o = bus.bus_dat_i;
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Transaction FSM; bus address/data/bsel are captured on leaving IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            bus_adr_r  <= 32'h0000_0000;
            bus_dat_r  <= 32'h0000_0000;
            bus_bsel_r <= 4'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        state_r    <= DRAIN;
                        bus_adr_r  <= head_s.adr;
                        bus_dat_r  <= head_s.dat;
                        bus_bsel_r <= head_s.bsel;
                    end else if (lsu_req_i && !lsu_we_i) begin
                        state_r    <= LOAD;
                        bus_adr_r  <= lsu_adr_i;
                        bus_bsel_r <= lsu_bsel_i;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                DRAIN, LOAD: begin
                    if (bus.bus_ack_i || bus.bus_err_i) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky imprecise store error; a drain error outranks a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_err_r <= 1'b0;
        end else if ((state_r == DRAIN) && bus.bus_err_i) begin
            store_err_r <= 1'b1;
        end else if (store_err_clr_i) begin
            store_err_r <= 1'b0;
        end else begin
            store_err_r <= store_err_r;
        end
    end

    assign bus.bus_req_o   = (state_r != IDLE);
    assign bus.bus_we_o    = (state_r == DRAIN);
    assign bus.bus_adr_o   = bus_adr_r;
    assign bus.bus_dat_o   = bus_dat_r;
    assign bus.bus_bsel_o  = bus_bsel_r;
    assign bus.bus_burst_o = 1'b0;

    assign sb_full_o   = fifo_full_s;
    assign sb_empty_o  = (fifo_count_s == '0) && (state_r != DRAIN);
    assign store_err_o = store_err_r;

endmodule
